uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter and sequencer that shares one 128-bit packet UART transmitter (`p_uart_send`) between two requesters. Typical requesters are the `i_loop` echo path and a status/report source. The block latches the granted packet and issues a single-cycle launch strobe. It then tracks the transmitter's busy flag through the whole packet and enforces a minimum inter-packet gap before the next grant. It sits in `top` between the requesters and `u_p_uart_send`, and owns that module's `uart_en` and `uart_din`.

## Interface
- `START_TIMEOUT`, 16: max cycles to wait for `tx_busy` to rise after a launch (range 2..255).
- `GAP_CYCLES`, 4: idle cycles enforced after `tx_busy` falls, before the next grant (0..255; 0 = no gap).

Ports:
- `sys_clk` in 1: system clock (50 MHz).
- `sys_rst_n` in 1: asynchronous active-low reset. One clock domain, asynchronous assert.
- `req0_valid` in 1: requester 0 has a packet. Must be held with stable data until `req0_ready` is seen.
- `req0_data` in 128: requester 0 packet.
- `req0_ready` out 1: one-cycle grant/accept pulse to requester 0.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `tx_busy` in 1: from `p_uart_send.uart_tx_busy`.
- `send_en` out 1: one-cycle launch strobe, to `p_uart_send.uart_en`.
- `send_data` out 128: registered packet, to `p_uart_send.uart_din`. Held stable until the next grant.
- `grant_id` out 1: requester index of the most recent grant.
- `arb_busy` out 1: high in every state except IDLE.
- `err_clr` in 1: clears `err_timeout`.
- `err_timeout` out 1: sticky flag. Set when a launch never saw `tx_busy` rise.

## Operation
- Reset values: state IDLE, `send_en`=0, `send_data`=0, `req0_ready`=`req1_ready`=0, `grant_id`=1 (so requester 0 wins the first contest), `arb_busy`=0, `err_timeout`=0, counters 0.

States:
- **IDLE**
  - No valid request: stay in IDLE.
  - Exactly one requester valid: grant that requester.
  - Both valid: grant `~grant_id` (alternate).
  - On grant, in one edge:
    - `send_data` <= the granted data.
    - The granted `reqN_ready` goes to 1.
    - `send_en` goes to 1.
    - `grant_id` <= N.
    - Next state is WAIT_RISE.
- **WAIT_RISE**
  - `send_en` and `ready` return to 0 after one cycle.
  - Counter increments every cycle.
  - `tx_busy`=1: go to WAIT_FALL.
  - Counter reaches START_TIMEOUT with `tx_busy` still 0: set `err_timeout`, go to GAP.
- **WAIT_FALL**
  - Stay while `tx_busy`=1.
  - On `tx_busy`=0, go to GAP. No timeout applies in this state.
- **GAP**
  - Count GAP_CYCLES cycles, then go to IDLE.
  - With GAP_CYCLES=0, GAP lasts 0 cycles: WAIT_FALL goes straight to IDLE.
- `valid` is sampled only in IDLE. `valid` changes in other states are ignored.
- A requester that deasserts `valid` before being granted is simply not served. No packet is lost inside the arbiter.
- `err_clr` has priority over a simultaneous set: `err_timeout` ends at 0.
- Reset mid-packet:
  - Everything returns to reset values immediately, asynchronously.
  - The packet in flight in `p_uart_send` is not tracked.
  - `send_en` must never glitch high during or after reset.

## Timing
- Grant latency: `valid` high at edge k while in IDLE → `ready`/`send_en` high for the cycle after edge k, and low again after edge k+1.
- `send_data` is valid in the same cycle as `send_en` and stays unchanged until the next grant.
- Minimum grant-to-grant period: 1 (grant) + cycles until busy rises + busy duration + GAP_CYCLES + 1 (IDLE).
- Round robin holds under continuous load: with both requesters always valid, grants strictly alternate 0,1,0,1…
- All outputs are registered. No combinational path from any input to any output.

## Test plan
1. **Single request.** `req0_valid` with data `128'h0011…EEFF`; model `tx_busy` rising 2 cycles after `send_en` and lasting 100 cycles.
   - Expect exactly one `send_en` pulse and one `req0_ready` pulse in the same cycle.
   - Expect `send_data` = `128'h0011…EEFF`, `grant_id`=0, `arb_busy` low again 100+GAP+… cycles later.
2. **Simultaneous requests after reset**, data A on port 0 and B on port 1.
   - Expect A sent first, then B, and no second `send_en` before `tx_busy` falls plus 4 gap cycles.
3. **Fairness.** Both requesters held valid for 6 packets.
   - Expect the `grant_id` sequence 0,1,0,1,0,1 and 6 `send_en` pulses total.
4. **Start timeout.** `tx_busy` tied 0, START_TIMEOUT=16.
   - Expect `err_timeout` set 16 cycles after `send_en`, and a return to IDLE after the gap.
   - A second request is still served.
   - `err_clr` pulse clears the flag. `err_clr` asserted in the set cycle leaves it at 0.
5. **Reset mid-packet.** Assert `sys_rst_n`=0 in WAIT_FALL.
   - All outputs are at reset values before the next edge.
   - After release, a pending request is served by requester 0 first.
6. **GAP_CYCLES=0.** Expect the next `send_en` exactly 2 cycles after `tx_busy` falls when a request is pending.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one packet UART transmitter between two requesters.
// It latches the granted packet, strobes a launch, follows tx_busy, and then holds an inter-packet gap.
module uart_tx_arb #(
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  input  logic         tx_busy,
  output logic         send_en,
  output logic [127:0] send_data,
  output logic         grant_id,
  output logic         arb_busy,
  input  logic         err_clr,
  output logic         err_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL, GAP} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(START_TIMEOUT);
  localparam logic [7:0] GAP_LIM     = 8'(GAP_CYCLES);
  // With no gap configured, the end of a packet returns straight to IDLE.
  localparam state_t     AFTER_TX    = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next, cnt_inc;
  logic       grant, grant_sel, timeout_hit;
  logic       send_en_d, ready0_d, ready1_d, err_d;

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every signal gets a default before the case statement, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    cnt_inc     = cnt + 8'd1;
    timeout_hit = 1'b0;
    grant       = req0_valid | req1_valid;
    grant_sel   = (req0_valid & req1_valid) ? ~grant_id : req1_valid;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_next = WAIT_FALL;
          cnt_next   = '0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          timeout_hit = 1'b1;
          state_next  = AFTER_TX;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) begin
          state_next = AFTER_TX;
          cnt_next   = '0;
        end
      end
      GAP: begin
        if (cnt_inc == GAP_LIM) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    send_en_d = (state == IDLE) && grant;
    ready0_d  = send_en_d && !grant_sel;
    ready1_d  = send_en_d && grant_sel;
    // A clear in the same cycle as a timeout wins.
    err_d     = err_clr ? 1'b0 : (err_timeout | timeout_hit);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      send_en     <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      send_data   <= '0;
      grant_id    <= 1'b1;
      arb_busy    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      send_en     <= send_en_d;
      req0_ready  <= ready0_d;
      req1_ready  <= ready1_d;
      arb_busy    <= (state_next != IDLE);
      err_timeout <= err_d;
      if (send_en_d) begin
        send_data <= grant_sel ? req1_data : req0_data;
        grant_id  <= grant_sel;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a launch scoreboard, a table of arbitration vectors,
// and hand-written sequences for the timeout, reset, and zero-gap cases.
module tb_uart_tx_arb;

  typedef struct {
    logic         id;
    logic [127:0] data;
  } sb_t;

  typedef struct {
    logic r0v;
    logic r1v;
    logic exp_id;
  } vec_t;

  localparam logic [127:0] PKT1 = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         tx_busy = 1'b0;
  logic         send_en;
  logic [127:0] send_data;
  logic         grant_id, arb_busy;
  logic         err_clr = 1'b0;
  logic         err_timeout;

  logic         g_req0_valid = 1'b0, g_req1_valid = 1'b0, g_tx_busy = 1'b0;
  logic         g_req0_ready, g_req1_ready, g_send_en, g_grant_id, g_arb_busy, g_err_timeout;
  logic [127:0] g_send_data;

  int  n_cmp = 0, n_err = 0;
  int  cyc = 0, n_sends = 0, last_send = 0, prev_send = 0;
  bit  prev_en = 1'b0;
  bit  busy_on = 1'b1;
  int  busy_delay = 2, busy_len = 100;
  sb_t sb[$];
  sb_t sb_e;

  uart_tx_arb #(.START_TIMEOUT(16), .GAP_CYCLES(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_busy(tx_busy), .send_en(send_en), .send_data(send_data),
    .grant_id(grant_id), .arb_busy(arb_busy),
    .err_clr(err_clr), .err_timeout(err_timeout)
  );

  uart_tx_arb #(.START_TIMEOUT(16), .GAP_CYCLES(0)) dut_g0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0_valid(g_req0_valid), .req0_data(req0_data), .req0_ready(g_req0_ready),
    .req1_valid(g_req1_valid), .req1_data(req1_data), .req1_ready(g_req1_ready),
    .tx_busy(g_tx_busy), .send_en(g_send_en), .send_data(g_send_data),
    .grant_id(g_grant_id), .arb_busy(g_arb_busy),
    .err_clr(err_clr), .err_timeout(g_err_timeout)
  );

  initial forever #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not seen within %0d cycles (cycle %0d)", name, budget, cyc);
  endtask

  task automatic wait_ready(input logic which, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (which ? req1_ready : req0_ready) break;
    end
    if (k == budget) timeout_fail(which ? "wait_ready1" : "wait_ready0", budget);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!arb_busy) break;
    end
    if (k == budget) timeout_fail("wait_idle", budget);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every launch must match the oldest expected packet.
  initial forever begin
    @(negedge clk);
    if (send_en && prev_en) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_en_width: send_en high for two cycles (cycle %0d)", cyc);
    end
    if (send_en) begin
      prev_send = last_send;
      last_send = cyc;
      n_sends++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: unexpected send_en, grant_id=%0d data=%h", grant_id, send_data);
      end else begin
        sb_e = sb.pop_front();
        check("sb_grant_id", grant_id, sb_e.id);
        check("sb_send_data", send_data, sb_e.data);
        check("sb_ready", {req1_ready, req0_ready}, sb_e.id ? 2'b10 : 2'b01);
      end
    end else if (req0_ready || req1_ready) begin
      check("stray_ready", {req1_ready, req0_ready}, 2'b00);
    end
    prev_en = send_en;
  end

  // Transmitter model: busy rises busy_delay cycles after a launch and lasts busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (send_en && busy_on) begin
      repeat (busy_delay - 1) @(negedge clk);
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  initial begin
    vec_t         vecs[8];
    logic [127:0] d0, d1, a, b;
    int           k, cnt6, sends0;

    vecs[0] = '{1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_send_en", send_en, 0);
    check("rst_send_data", send_data, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_grant_id", grant_id, 1);
    check("rst_arb_busy", arb_busy, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_send_en", send_en, 0);

    // Single request, busy 2 cycles after launch for 100 cycles
    sends0 = n_sends;
    req0_data = PKT1;
    req0_valid = 1'b1;
    sb.push_back('{1'b0, PKT1});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (!arb_busy) break;
    end
    check("t1_busy_cycles", k, 106);
    check("t1_send_count", n_sends - sends0, 1);
    check("t1_send_data", send_data, PKT1);
    check("t1_grant_id", grant_id, 0);

    // Simultaneous requests after reset
    pulse_reset();
    busy_len = 10;
    a = {4{$urandom}};
    b = {4{$urandom}};
    req0_data = a;
    req1_data = b;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sb.push_back('{1'b0, a});
    sb.push_back('{1'b1, b});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    wait_ready(1'b1, 60);
    req1_valid = 1'b0;
    check("t2_grant_period", last_send - prev_send, 17);
    wait_idle(60);

    // Fairness under continuous load
    cnt6 = 0;
    for (int i = 0; i < 6; i++) sb.push_back('{i[0], i[0] ? b : a});
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (send_en) cnt6++;
      if (cnt6 == 6) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_send_count", cnt6, 6);
    wait_idle(60);

    // Table-driven arbitration vectors
    busy_len = 3;
    for (int i = 0; i < 8; i++) begin
      d0 = {$urandom, $urandom, $urandom, $urandom};
      d1 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      req0_data = d0;
      req1_data = d1;
      req0_valid = vecs[i].r0v;
      req1_valid = vecs[i].r1v;
      sb.push_back('{vecs[i].exp_id, vecs[i].exp_id ? d1 : d0});
      wait_ready(vecs[i].exp_id, 8);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(60);
      check("tbl_data_held", send_data, vecs[i].exp_id ? d1 : d0);
      check("tbl_grant_id", grant_id, vecs[i].exp_id);
    end

    // Start timeout
    busy_on = 1'b0;
    @(negedge clk);
    req0_data = PKT1;
    req0_valid = 1'b1;
    sb.push_back('{1'b0, PKT1});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_err_before", err_timeout, 0);
    @(negedge clk);
    check("t4_err_set", err_timeout, 1);
    repeat (3) @(negedge clk);
    check("t4_gap_busy", arb_busy, 1);
    @(negedge clk);
    check("t4_gap_idle", arb_busy, 0);
    req1_data = PKT1 ^ {128{1'b1}};
    req1_valid = 1'b1;
    sb.push_back('{1'b1, PKT1 ^ {128{1'b1}}});
    wait_ready(1'b1, 8);
    req1_valid = 1'b0;
    wait_idle(60);
    check("t4_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", err_timeout, 0);
    req0_valid = 1'b1;
    sb.push_back('{1'b0, PKT1});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    repeat (15) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_clr_wins", err_timeout, 0);
    wait_idle(60);

    // Reset mid-packet while in WAIT_FALL
    a = {4{$urandom}};
    req0_data = a;
    req0_valid = 1'b1;
    sb.push_back('{1'b0, a});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_pre_busy", arb_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_send_en", send_en, 0);
    check("t5_send_data", send_data, 0);
    check("t5_ready", {req1_ready, req0_ready}, 0);
    check("t5_grant_id", grant_id, 1);
    check("t5_arb_busy", arb_busy, 0);
    check("t5_err", err_timeout, 0);
    @(negedge clk);
    check("t5_send_en_hold", send_en, 0);
    tx_busy = 1'b0;
    rst_n = 1'b1;
    b = {4{$urandom}};
    req1_data = b;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sb.push_back('{1'b0, a});
    sb.push_back('{1'b1, b});
    wait_ready(1'b0, 8);
    req0_valid = 1'b0;
    wait_ready(1'b1, 60);
    req1_valid = 1'b0;
    wait_idle(60);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Zero-gap instance: next launch two cycles after busy falls
    g_req0_valid = 1'b1;
    g_req1_valid = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (g_send_en) break;
    end
    if (k == 8) timeout_fail("t6_first_send", 8);
    check("t6_first_id", g_grant_id, 0);
    g_req0_valid = 1'b0;
    @(negedge clk);
    g_tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    g_tx_busy = 1'b0;
    @(negedge clk);
    check("t6_no_early_send", g_send_en, 0);
    @(negedge clk);
    check("t6_send_at_2", g_send_en, 1);
    check("t6_second_id", g_grant_id, 1);
    check("t6_second_data", g_send_data, b);
    g_req1_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_idle", g_arb_busy, 0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
